// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER counter: FSM state encoding, step/index sizing,
// and the saturating add used when BER_SAT_EN is defined.
package ber_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        UPDATE = 2'd2
    } state_e;

    function automatic int steps_of(input int dim, input int chunk);
        return dim / chunk;
    endfunction

    // Index register width; a single-step frame still needs one bit.
    function automatic int idx_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    // Adds on a 65-bit path so the carry is visible, then clamps to the w-bit all-ones value.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (w >= 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << w) - 65'd1);
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/ber_counter_popcnt.sv
// Combinational population count of a CHUNK-bit slice, built as a recursive adder tree
// that splits uneven widths into floor/ceil halves.
module popcnt #(
    parameter  int CHUNK = 64,
    localparam int CNT_W = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [CNT_W-1:0] cnt
);

    generate
        if (CHUNK == 1) begin : g_leaf
            assign cnt = bits;
        end else begin : g_split
            localparam int LO   = CHUNK / 2;
            localparam int HI   = CHUNK - LO;
            localparam int LO_W = $clog2(LO + 1);
            localparam int HI_W = $clog2(HI + 1);

            logic [LO_W-1:0] cnt_lo;
            logic [HI_W-1:0] cnt_hi;

            popcnt #(.CHUNK(LO)) u_lo (.bits(bits[LO-1:0]),     .cnt(cnt_lo));
            popcnt #(.CHUNK(HI)) u_hi (.bits(bits[CHUNK-1:LO]), .cnt(cnt_hi));

            assign cnt = CNT_W'(cnt_lo) + CNT_W'(cnt_hi);
        end
    endgenerate

endmodule

// File: rtl/ber_counter.sv
// Bit-error-rate statistics for the all-zero-codeword LDPC harness: popcounts each captured
// frame CHUNK bits per cycle. Define BER_SAT_EN to make the cumulative counters saturate.
module ber_counter
    import ber_pkg::*;
#(
    parameter int R     = 24,
    parameter int D     = 96,
    parameter int CHUNK = 64,
    parameter int ERR_W = 12,
    parameter int ACC_W = 32,
    parameter int FRM_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             term,
    input  logic [R*D-1:0]   res,
    input  logic             clr,
    output logic [ERR_W-1:0] errs,
    output logic [ACC_W-1:0] bit_errs,
    output logic [FRM_W-1:0] frame_errs,
    output logic [FRM_W-1:0] frames,
    output logic             done,
    output logic             busy,
    output logic             overrun
);

    localparam int DIM    = R * D;
    localparam int STEPS  = steps_of(DIM, CHUNK);
    localparam int IDX_W  = idx_w(STEPS);
    localparam int FACC_W = $clog2(DIM + 1);
    localparam int CNT_W  = $clog2(CHUNK + 1);

    state_e             state_q, state_d;
    logic               term_q, term_d;
    logic [DIM-1:0]     shadow_q, shadow_d;
    logic [FACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ERR_W-1:0]   errs_q, errs_d;
    logic [ACC_W-1:0]   bit_errs_q, bit_errs_d;
    logic [FRM_W-1:0]   frame_errs_q, frame_errs_d;
    logic [FRM_W-1:0]   frames_q, frames_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;

    logic               start;
    logic [CNT_W-1:0]   chunk_cnt;

    popcnt #(.CHUNK(CHUNK)) u_popcnt (
        .bits (shadow_q[idx_q*CHUNK +: CHUNK]),
        .cnt  (chunk_cnt)
    );

    // term_q resets high so a term level held through reset never looks like a rising edge.
    assign term_d = term;
    assign start  = term & ~term_q;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        errs_d       = errs_q;
        bit_errs_d   = bit_errs_q;
        frame_errs_d = frame_errs_q;
        frames_d     = frames_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = res;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                if (start) overrun_d = 1'b1;
                acc_d = acc_q + FACC_W'(chunk_cnt);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(STEPS - 1)) state_d = UPDATE;
            end
            UPDATE: begin
                if (start) overrun_d = 1'b1;
                errs_d = ERR_W'(acc_q);
                done_d = 1'b1;
`ifdef BER_SAT_EN
                bit_errs_d   = ACC_W'(sat_add(64'(bit_errs_q), 64'(acc_q), ACC_W));
                frames_d     = FRM_W'(sat_add(64'(frames_q), 64'd1, FRM_W));
                frame_errs_d = FRM_W'(sat_add(64'(frame_errs_q), 64'(acc_q != '0), FRM_W));
`else
                bit_errs_d   = bit_errs_q + ACC_W'(acc_q);
                frames_d     = frames_q + FRM_W'(1);
                frame_errs_d = frame_errs_q + FRM_W'(acc_q != '0);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides this cycle's increments; errs and done of an UPDATE still go out.
        if (clr) begin
            bit_errs_d   = '0;
            frame_errs_d = '0;
            frames_d     = '0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            term_q       <= 1'b1;
            idx_q        <= '0;
            errs_q       <= '0;
            bit_errs_q   <= '0;
            frame_errs_q <= '0;
            frames_q     <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            term_q       <= term_d;
            idx_q        <= idx_d;
            errs_q       <= errs_d;
            bit_errs_q   <= bit_errs_d;
            frame_errs_q <= frame_errs_d;
            frames_q     <= frames_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Frame datapath: always loaded before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
        acc_q    <= acc_d;
    end

    assign errs       = errs_q;
    assign bit_errs   = bit_errs_q;
    assign frame_errs = frame_errs_q;
    assign frames     = frames_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ber_counter.sv
// Directed bench for ber_counter with a scoreboard of per-frame expected statistics;
// a second instance with ACC_W = 8 exercises wrap/saturation of bit_errs.
module tb_ber_counter;

    localparam int DIM   = 2304;
    localparam int STEPS = 36;
    localparam int LAT   = STEPS + 2;   // posedges from the start edge through the update edge

    logic            clk = 1'b0;
    logic            rst;
    logic            term;
    logic [DIM-1:0]  res;
    logic            clr;

    logic [11:0]     errs;
    logic [31:0]     bit_errs;
    logic [23:0]     frame_errs, frames;
    logic            done, busy, overrun;

    logic [11:0]     errs8;
    logic [7:0]      bit_errs8;
    logic [23:0]     frame_errs8, frames8;
    logic            done8, busy8, overrun8;

    always #5 clk = ~clk;

    ber_counter u_dut (
        .clk(clk), .rst(rst), .term(term), .res(res), .clr(clr),
        .errs(errs), .bit_errs(bit_errs), .frame_errs(frame_errs), .frames(frames),
        .done(done), .busy(busy), .overrun(overrun)
    );

    ber_counter #(.ACC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .term(term), .res(res), .clr(clr),
        .errs(errs8), .bit_errs(bit_errs8), .frame_errs(frame_errs8), .frames(frames8),
        .done(done8), .busy(busy8), .overrun(overrun8)
    );

    typedef struct {
        logic [63:0] errs;
        logic [63:0] bit32;
        logic [63:0] bit8;
        logic [63:0] ferr;
        logic [63:0] frames;
        logic [63:0] ovr;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] m_bit32, m_bit8, m_ferr, m_frames, m_ovr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] upd8(input logic [63:0] old, input int n);
        logic [63:0] s;
        s = old + 64'(n);
`ifdef BER_SAT_EN
        return (s > 64'd255) ? 64'd255 : s;
`else
        return s & 64'hFF;
`endif
    endfunction

    task automatic model_clear();
        m_bit32 = 0; m_bit8 = 0; m_ferr = 0; m_frames = 0; m_ovr = 0;
    endtask

    // Runs one frame. retrig_c > 0: term drops after posedge retrig_c and rises after the next,
    // with res changed to all ones. clr_edge > 0: clr is high at that posedge (1 = start edge).
    task automatic send_frame(input string name, input logic [DIM-1:0] r,
                              input int retrig_c, input int clr_edge);
        exp_t e;
        exp_t got_e;
        int   n;
        int   c;
        bit   got;

        @(negedge clk);
        term = 1'b0;
        res  = r;
        @(negedge clk);
        term = 1'b1;

        n = $countones(r);
        if (clr_edge > 0 && clr_edge < LAT) model_clear();
        if (retrig_c > 0) m_ovr = 1;
        if (clr_edge == LAT) begin
            model_clear();
        end else begin
            m_bit32  = (m_bit32 + 64'(n)) & 64'hFFFF_FFFF;
            m_bit8   = upd8(m_bit8, n);
            m_ferr   = m_ferr + 64'(n != 0);
            m_frames = m_frames + 1;
        end
        e.errs = 64'(n); e.bit32 = m_bit32; e.bit8 = m_bit8;
        e.ferr = m_ferr; e.frames = m_frames; e.ovr = m_ovr;
        sb.push_back(e);

        c   = 0;
        got = 1'b0;
        while (c < 100 && !got) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 1) check({name, "_busy_start"}, 64'(busy), 64'd1);
            if (done) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                if (retrig_c > 0 && c == retrig_c) begin
                    term = 1'b0;
                    res  = '1;
                end
                if (retrig_c > 0 && c == retrig_c + 1) term = 1'b1;
                clr = (clr_edge > 0 && c + 1 == clr_edge);
            end
        end

        if (!got) begin
            check({name, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            check({name, "_latency"}, 64'(c), 64'(LAT));
            check({name, "_busy_done"}, 64'(busy), 64'd0);
            got_e = sb.pop_front();
            check({name, "_errs"},       64'(errs),       got_e.errs);
            check({name, "_bit_errs"},   64'(bit_errs),   got_e.bit32);
            check({name, "_bit_errs8"},  64'(bit_errs8),  got_e.bit8);
            check({name, "_frame_errs"}, 64'(frame_errs), got_e.ferr);
            check({name, "_frames"},     64'(frames),     got_e.frames);
            check({name, "_frames8"},    64'(frames8),    got_e.frames);
            check({name, "_overrun"},    64'(overrun),    got_e.ovr);
        end

        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    logic [DIM-1:0] pat;
    int             pulses;

    initial begin
        rst  = 1'b1;
        term = 1'b1;
        clr  = 1'b0;
        res  = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, with term held high through reset.
        #1;
        check("rst_errs",       64'(errs),       64'd0);
        check("rst_bit_errs",   64'(bit_errs),   64'd0);
        check("rst_frame_errs", 64'(frame_errs), 64'd0);
        check("rst_frames",     64'(frames),     64'd0);
        check("rst_done",       64'(done),       64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_overrun",    64'(overrun),    64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("held_term_busy",   64'(busy),   64'd0);
        check("held_term_frames", 64'(frames), 64'd0);

        send_frame("zero", '0, 0, 0);

        pat = '0;
        pat[0] = 1'b1; pat[63] = 1'b1; pat[64] = 1'b1; pat[DIM-1] = 1'b1;
        send_frame("bound1", pat, 0, 0);
        send_frame("bound2", pat, 0, 0);

        send_frame("ones", '1, 0, 0);

        pat = '0;
        for (int i = 0; i < 5; i++) pat[i*300+7] = 1'b1;
        send_frame("overrun", pat, 9, 0);

        pat = '0;
        pat[100] = 1'b1; pat[1000] = 1'b1; pat[2000] = 1'b1;
        send_frame("clr_count", pat, 0, 11);

        send_frame("clr_update", pat, 0, LAT);

        pat = '0;
        for (int i = 0; i < 200; i++) pat[i*11] = 1'b1;
        send_frame("sat1", pat, 0, 0);
        send_frame("sat2", pat, 0, 0);

        // Reset mid-COUNT with term held high: frame abandoned, no new start until term toggles.
        @(negedge clk);
        term = 1'b0;
        @(negedge clk);
        term = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy",     64'(busy),     64'd0);
        check("midrst_frames",   64'(frames),   64'd0);
        check("midrst_bit_errs", 64'(bit_errs), 64'd0);
        check("midrst_errs",     64'(errs),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midrst_no_done",   64'(pulses), 64'd0);
        check("midrst_idle_busy", 64'(busy),   64'd0);
        check("midrst_idle_frm",  64'(frames), 64'd0);

        pat = '0;
        pat[1234] = 1'b1;
        send_frame("after_rst", pat, 0, 0);

        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ber_counter.md
# ber_counter

Downstream error-statistics stage for the LDPC decoder test harness. It watches the decoder's `term` flag and captures the decoded hard-decision word `res`. Because the harness transmits the all-zero codeword, every `1` in `res` is a bit error. The block counts those errors over several cycles, `CHUNK` bits per cycle, then updates per-frame and cumulative BER counters, including the 12-bit `errs` output consumed by the harness top.

## Interface

**Parameters**
- `R`, default 24: base-matrix columns.
- `D`, default 96: expansion factor. Frame length `DIM = R*D` (2304).
- `CHUNK`, default 64: bits popcounted per cycle. `DIM % CHUNK == 0` is required; `STEPS = DIM/CHUNK` (36).
- `ERR_W`, default 12: width of `errs`. `2^ERR_W > DIM` is required.
- `ACC_W`, default 32: width of the cumulative bit-error counter.
- `FRM_W`, default 24: width of the frame counters.

**Ports**
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `term`  in  1  decoder done, level. `res` is stable while `term` is high.
- `res`  in  DIM  decoded hard bits; `1` = error.
- `clr`  in  1  synchronous clear of the cumulative counters and `overrun`.
- `errs`  out  ERR_W  error count of the last completed frame.
- `bit_errs`  out  ACC_W  cumulative bit errors.
- `frame_errs`  out  FRM_W  frames with `errs != 0`.
- `frames`  out  FRM_W  frames counted.
- `done`  out  1  one-cycle pulse when the outputs update.
- `busy`  out  1  high when the state is not IDLE.
- `overrun`  out  1  sticky: a frame was dropped.

## Operation

- **Edge detect.**
  - `term_q` registers `term` and resets to 1.
  - A frame start is `term & ~term_q`, sampled in IDLE.
  - A `term` held high through reset is not counted; `term` must go low, then high.
- **FSM states: IDLE, COUNT, UPDATE.**
- **IDLE.**
  - On a start: `shadow <= res`, `acc <= 0`, `idx <= 0`, go to COUNT.
- **COUNT.**
  - Each cycle: `acc <= acc + popcnt(shadow[idx*CHUNK +: CHUNK])`, `idx <= idx+1`.
  - After the add with `idx == STEPS-1`, go to UPDATE.
  - `acc` and `idx` are sized with `clog2` and never overflow.
- **UPDATE.** Go to IDLE and apply:
  - `errs <= acc`
  - `bit_errs += acc`
  - `frames += 1`
  - `frame_errs += (acc != 0)`
  - `done <= 1` for one cycle
- **Dropped frames.** A start detected while in COUNT or UPDATE is dropped and sets `overrun`. `shadow` is untouched.
- **`clr` in any state.**
  - Zeroes `bit_errs`, `frame_errs`, `frames` and `overrun`.
  - `clr` wins over a simultaneous UPDATE: that frame's increments are lost, but `errs` and `done` still issue.
  - A frame in COUNT when `clr` is asserted completes and is counted on the cleared base.
- **Reset.** Asynchronous. All outputs are 0, `term_q` = 1, the state is IDLE. Reset mid-COUNT abandons the frame.

## Timing

- Start sampled at edge k.
- COUNT occupies edges k+1 … k+STEPS.
- The outputs and `done` update at edge k+STEPS+1, which is 37 cycles with the defaults.
- `busy` is high from edge k to edge k+STEPS+1, exclusive of the latter.
- Minimum spacing between accepted frames is STEPS+2 cycles: `term` must fall and rise again after IDLE is re-entered.
- All outputs are registered. `res` is only sampled at the start edge.

## Configuration

- **`BER_SAT_EN` defined:** `bit_errs`, `frame_errs` and `frames` saturate at all-ones and hold there until `clr` or `rst`.
- **`BER_SAT_EN` undefined:** the same counters wrap modulo 2^width.
- `errs` never saturates in either mode; its width is guaranteed by the `ERR_W` requirement.

## Structure

- **Package `ber_pkg`:** the state enum (IDLE/COUNT/UPDATE), a `clog2`-based `STEPS`/index-width helper, and a saturating-add function used under `BER_SAT_EN`.
- **One sub-module, `popcnt`:** combinational `CHUNK`-bit population count built as an adder tree, with output width `clog2(CHUNK+1)`.

## Test plan

- **All-zero frame.** `res` = 0, `term` 0→1 → at edge k+37: `done` = 1, `errs` = 0, `frames` = 1, `frame_errs` = 0, `bit_errs` = 0.
- **Chunk-boundary bits.** Bits 0, 63, 64 and 2303 set → `errs` = 4, `bit_errs` = 4, `frame_errs` = 1. A second identical frame → `bit_errs` = 8, `frames` = 2.
- **All-ones frame.** `res` all ones → `errs` = 2304, `bit_errs` = 2304.
- **Overrun.** `term` falls and rises at edge k+10 (during COUNT) → `overrun` = 1, `frames` = 1 after completion, and `errs` reflects the first frame only.
- **Saturation with `ACC_W` = 8.** Two frames of 200 errors each. With `BER_SAT_EN`: `bit_errs` = 200, then 255. Without it: 200, then 144.
- **Reset and clear.**
  - `rst` pulsed at edge k+20 with `term` held high → outputs 0, `busy` = 0, and no frame counted until `term` goes 0 then 1.
  - `clr` coincident with UPDATE → `frames` = 0 and `done` = 1.
